// File: rtl/neureka_package.sv
// rtl/neureka_package.sv - shared types and constants for the neureka accumulator drain stage
package neureka_package;

    localparam int NEUREKA_SO_OUT_WIDTH = 8;

    typedef enum logic [1:0] {
        SO_IDLE,
        SO_FETCH,
        SO_PACK_OUT,
        SO_CLEAR
    } streamout_state_e;

endpackage

// File: rtl/neureka_streamout_quant.sv
// rtl/neureka_streamout_quant.sv - single-word requant: round, arithmetic shift, relu, saturate
module neureka_streamout_quant #(
    parameter int DATA_WIDTH  = 32,
    parameter int OUT_WIDTH   = 8,
    parameter int SHIFT_WIDTH = 5
) (
    input  logic [DATA_WIDTH-1:0]  data_i,
    input  logic [SHIFT_WIDTH-1:0] shift_i,
    input  logic                   relu_en_i,
    output logic [OUT_WIDTH-1:0]   data_o
);

    localparam logic signed [DATA_WIDTH:0] SAT_MAX = (DATA_WIDTH+1)'((1 << (OUT_WIDTH-1)) - 1);
    localparam logic signed [DATA_WIDTH:0] SAT_MIN = ~SAT_MAX;

    logic signed [DATA_WIDTH:0] round_bias;
    logic signed [DATA_WIDTH:0] biased;
    logic signed [DATA_WIDTH:0] shifted;

    // One extra bit of headroom so the rounding bias can never wrap the word.
    always_comb begin
        round_bias = '0;
        if (shift_i != '0) begin
            round_bias = (DATA_WIDTH+1)'(1) << (shift_i - 1'b1);
        end
        biased  = $signed({data_i[DATA_WIDTH-1], data_i}) + round_bias;
        shifted = biased >>> shift_i;
        if (relu_en_i && shifted[DATA_WIDTH]) begin
            shifted = '0;
        end
        if (shifted > SAT_MAX) begin
            data_o = SAT_MAX[OUT_WIDTH-1:0];
        end else if (shifted < SAT_MIN) begin
            data_o = SAT_MIN[OUT_WIDTH-1:0];
        end else begin
            data_o = shifted[OUT_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/neureka_accumulator_streamout.sv
// rtl/neureka_accumulator_streamout.sv - drains the accumulator buffer as raw words or packed int8
module neureka_accumulator_streamout
    import neureka_package::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_WORDS    = 32,
    parameter int WIDTH_FACTOR = 8,
    parameter int OUT_WIDTH    = NEUREKA_SO_OUT_WIDTH,
    parameter int SHIFT_WIDTH  = 5,
    localparam int ADDR_WIDTH   = $clog2(NUM_WORDS),
    localparam int STREAM_WIDTH = WIDTH_FACTOR * DATA_WIDTH
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      clear_i,
    input  logic                      start_i,
    input  logic                      quant_en_i,
    input  logic                      relu_en_i,
    input  logic [SHIFT_WIDTH-1:0]    shift_i,
    input  logic [ADDR_WIDTH:0]       word_count_i,
    output logic [ADDR_WIDTH-1:0]     acc_raddr_o,
    input  logic [STREAM_WIDTH-1:0]   acc_rdata_wide_i,
    output logic                      acc_clear_o,
    output logic                      stream_valid_o,
    input  logic                      stream_ready_i,
    output logic [STREAM_WIDTH-1:0]   stream_data_o,
    output logic [STREAM_WIDTH/8-1:0] stream_strb_o,
    output logic                      busy_o,
    output logic                      done_o
);

    localparam int CNT_WIDTH  = ADDR_WIDTH - 1;
    localparam int WC_WIDTH   = ADDR_WIDTH + 1;
    localparam int STRB_WIDTH = STREAM_WIDTH / 8;
    localparam int BPW        = DATA_WIDTH / 8;

    streamout_state_e state_q, state_d;

    logic [CNT_WIDTH-1:0]   chunk_cnt_q;
    logic                   last_loaded_q;
    logic                   quant_q, relu_q;
    logic [SHIFT_WIDTH-1:0] shift_q;
    logic [WC_WIDTH-1:0]    wc_q;

    logic                   idle, start_ok, accept, can_load, do_load, is_last;
    logic                   cur_quant, cur_relu;
    logic [SHIFT_WIDTH-1:0] cur_shift;
    logic [WC_WIDTH-1:0]    wc_sat, cur_wc, last_chunk;

    logic [WIDTH_FACTOR-1:0] word_valid;
    logic [OUT_WIDTH-1:0]    qraw  [WIDTH_FACTOR];
    logic [OUT_WIDTH-1:0]    qbyte [WIDTH_FACTOR];
    logic [STREAM_WIDTH-1:0] full_data, quant_pack;
    logic [STRB_WIDTH-1:0]   full_strb, quant_strb;

    // In IDLE the live inputs are used so chunk 0 can be consumed on the start edge itself.
    assign idle       = (state_q == SO_IDLE);
    assign wc_sat     = (word_count_i > WC_WIDTH'(NUM_WORDS)) ? WC_WIDTH'(NUM_WORDS) : word_count_i;
    assign cur_quant  = idle ? quant_en_i : quant_q;
    assign cur_relu   = idle ? relu_en_i  : relu_q;
    assign cur_shift  = idle ? shift_i    : shift_q;
    assign cur_wc     = idle ? wc_sat     : wc_q;
    assign last_chunk = (cur_wc - 1'b1) / WC_WIDTH'(WIDTH_FACTOR);
    assign is_last    = (last_chunk == WC_WIDTH'(chunk_cnt_q));
    assign start_ok   = start_i && (wc_sat != '0);
    assign accept     = stream_valid_o && stream_ready_i;
    assign can_load   = !stream_valid_o || stream_ready_i;

    assign acc_raddr_o = {chunk_cnt_q, 1'b0};
    assign busy_o      = !idle;
    assign acc_clear_o = (state_q == SO_CLEAR);
    assign done_o      = (state_q == SO_CLEAR);

    for (genvar j = 0; j < WIDTH_FACTOR; j++) begin : g_word
        assign word_valid[j] = (int'(chunk_cnt_q) * WIDTH_FACTOR + j) < int'(cur_wc);
        assign full_data[j*DATA_WIDTH +: DATA_WIDTH] =
            word_valid[j] ? acc_rdata_wide_i[j*DATA_WIDTH +: DATA_WIDTH] : '0;
        assign full_strb[j*BPW +: BPW] = {BPW{word_valid[j]}};
        assign qbyte[j] = word_valid[j] ? qraw[j] : '0;

        neureka_streamout_quant #(
            .DATA_WIDTH  (DATA_WIDTH),
            .OUT_WIDTH   (OUT_WIDTH),
            .SHIFT_WIDTH (SHIFT_WIDTH)
        ) u_quant (
            .data_i    (acc_rdata_wide_i[j*DATA_WIDTH +: DATA_WIDTH]),
            .shift_i   (cur_shift),
            .relu_en_i (cur_relu),
            .data_o    (qraw[j])
        );
    end

    // The output register doubles as the pack register; a new drain starts it from zero.
    always_comb begin
        quant_pack = idle ? '0 : stream_data_o;
        quant_strb = '0;
        for (int l = 0; l < STRB_WIDTH; l++) begin
            if (l / WIDTH_FACTOR == int'(chunk_cnt_q)) begin
                quant_pack[l*OUT_WIDTH +: OUT_WIDTH] = qbyte[l % WIDTH_FACTOR];
            end
            quant_strb[l] = (l < int'(cur_wc));
        end
    end

    always_comb begin
        state_d = state_q;
        do_load = 1'b0;
        case (state_q)
            SO_IDLE: begin
                if (start_ok) begin
                    do_load = 1'b1;
                    state_d = (cur_quant && is_last) ? SO_PACK_OUT : SO_FETCH;
                end
            end
            SO_FETCH: begin
                if (cur_quant) begin
                    do_load = 1'b1;
                    if (is_last) state_d = SO_PACK_OUT;
                end else if (!last_loaded_q) begin
                    do_load = can_load;
                end else if (accept) begin
                    state_d = SO_CLEAR;
                end
            end
            SO_PACK_OUT: begin
                if (stream_ready_i) state_d = SO_CLEAR;
            end
            SO_CLEAR: state_d = SO_IDLE;
            default:  state_d = SO_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state_q <= SO_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            chunk_cnt_q    <= '0;
            last_loaded_q  <= 1'b0;
            quant_q        <= 1'b0;
            relu_q         <= 1'b0;
            shift_q        <= '0;
            wc_q           <= '0;
            stream_valid_o <= 1'b0;
            stream_data_o  <= '0;
            stream_strb_o  <= '0;
        end else begin
            if (idle && start_ok) begin
                quant_q       <= quant_en_i;
                relu_q        <= relu_en_i;
                shift_q       <= shift_i;
                wc_q          <= wc_sat;
                last_loaded_q <= 1'b0;
            end
            // The counter parks on the last chunk so the read address never runs past the tile.
            if (do_load) begin
                if (is_last) last_loaded_q <= 1'b1;
                else         chunk_cnt_q   <= chunk_cnt_q + 1'b1;
                if (cur_quant) begin
                    stream_data_o <= quant_pack;
                    if (is_last) begin
                        stream_valid_o <= 1'b1;
                        stream_strb_o  <= quant_strb;
                    end
                end else begin
                    stream_data_o  <= full_data;
                    stream_strb_o  <= full_strb;
                    stream_valid_o <= 1'b1;
                end
            end else if (accept) begin
                stream_valid_o <= 1'b0;
            end
            if (state_q == SO_CLEAR) begin
                chunk_cnt_q   <= '0;
                last_loaded_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_neureka_accumulator_streamout.sv
// tb/tb_neureka_accumulator_streamout.sv - scoreboard bench for the accumulator drain stage
module tb_neureka_accumulator_streamout;

    localparam int NW = 32;

    typedef struct packed {
        logic [255:0] d;
        logic [31:0]  s;
    } beat_t;

    logic         clk_i = 1'b0;
    logic         rst_i, clear_i, start_i, quant_en_i, relu_en_i, stream_ready_i;
    logic [4:0]   shift_i;
    logic [5:0]   word_count_i;
    logic [4:0]   acc_raddr_o;
    logic [255:0] acc_rdata_wide_i;
    logic         acc_clear_o, stream_valid_o, busy_o, done_o;
    logic [255:0] stream_data_o;
    logic [31:0]  stream_strb_o;

    logic [31:0] mem [NW];
    beat_t       exp_q [$];
    int          n_checks = 0, n_fail = 0;
    int          n_beats = 0, n_clear = 0, n_done = 0, exp_done = 0;
    int          raddr_limit = 8;
    int          ready_mode = 0, pat_i = 0;
    logic [3:0]  rdy_pat = 4'b1001;

    always #5 clk_i = ~clk_i;

    for (genvar j = 0; j < 8; j++) begin : g_rd
        assign acc_rdata_wide_i[j*32 +: 32] =
            (int'(acc_raddr_o[4:1]) * 8 + j < NW) ? mem[int'(acc_raddr_o[4:1]) * 8 + j] : 32'h0;
    end

    neureka_accumulator_streamout dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .clear_i          (clear_i),
        .start_i          (start_i),
        .quant_en_i       (quant_en_i),
        .relu_en_i        (relu_en_i),
        .shift_i          (shift_i),
        .word_count_i     (word_count_i),
        .acc_raddr_o      (acc_raddr_o),
        .acc_rdata_wide_i (acc_rdata_wide_i),
        .acc_clear_o      (acc_clear_o),
        .stream_valid_o   (stream_valid_o),
        .stream_ready_i   (stream_ready_i),
        .stream_data_o    (stream_data_o),
        .stream_strb_o    (stream_strb_o),
        .busy_o           (busy_o),
        .done_o           (done_o)
    );

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic monitor();
        logic         stall_prev = 1'b0, abort_prev = 1'b1;
        logic [255:0] prev_d = '0;
        logic [31:0]  prev_s = '0;
        beat_t        b;
        forever begin
            @(negedge clk_i);
            if (!rst_i && !clear_i) begin
                if (stall_prev && !abort_prev) begin
                    chk("stall_valid", stream_valid_o, 1);
                    chk("stall_data", stream_data_o, prev_d);
                    chk("stall_strb", stream_strb_o, prev_s);
                end
                if (busy_o) chk("raddr_range", acc_raddr_o < raddr_limit, 1);
                if (stream_valid_o && stream_ready_i) begin
                    n_beats++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", 1, 0);
                    end else begin
                        b = exp_q.pop_front();
                        chk("beat_data", stream_data_o, b.d);
                        chk("beat_strb", stream_strb_o, b.s);
                    end
                end
            end
            if (acc_clear_o || done_o) chk("clear_done_pair", acc_clear_o, done_o);
            if (acc_clear_o) n_clear++;
            if (done_o) n_done++;
            stall_prev = stream_valid_o && !stream_ready_i;
            abort_prev = rst_i || clear_i;
            prev_d     = stream_data_o;
            prev_s     = stream_strb_o;
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
        case (ready_mode)
            0:       stream_ready_i = 1'b1;
            1:       begin stream_ready_i = rdy_pat[pat_i % 4]; pat_i++; end
            default: stream_ready_i = 1'b0;
        endcase
    endtask

    task automatic do_start(input logic q, input logic r, input logic [4:0] sh, input logic [5:0] wc);
        quant_en_i   = q;
        relu_en_i    = r;
        shift_i      = sh;
        word_count_i = wc;
        start_i      = 1'b1;
        step();
        start_i      = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0 = n_done;
        int k  = 0;
        while (n_done == d0 && k < budget) begin
            step();
            k++;
        end
        chk("done_timeout", n_done != d0, 1);
    endtask

    task automatic push_full(input int c, input int wc);
        beat_t b;
        b.d = '0;
        b.s = '0;
        for (int j = 0; j < 8; j++) begin
            if (c * 8 + j < wc) begin
                b.d[j*32 +: 32] = mem[c * 8 + j];
                b.s[j*4 +: 4]   = 4'hF;
            end
        end
        exp_q.push_back(b);
    endtask

    task automatic fill_index();
        for (int i = 0; i < NW; i++) mem[i] = i;
    endtask

    initial begin
        beat_t b;
        int    b0, c0;
        rst_i = 1'b1; clear_i = 1'b0; start_i = 1'b0; quant_en_i = 1'b0; relu_en_i = 1'b0;
        shift_i = '0; word_count_i = '0; stream_ready_i = 1'b1;
        fill_index();
        fork monitor(); join_none
        repeat (3) step();
        chk("rst_valid", stream_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_raddr", acc_raddr_o, 0);
        chk("rst_clear", acc_clear_o, 0);
        chk("rst_data", stream_data_o, 0);
        chk("rst_strb", stream_strb_o, 0);
        rst_i = 1'b0;
        step();

        // FULL, wc=32, continuous ready: beats on cycles 1-4, clear on cycle 5
        for (int c = 0; c < 4; c++) push_full(c, 32);
        do_start(1'b0, 1'b0, 5'd0, 6'd32);
        chk("t1_first_valid", stream_valid_o, 1);
        chk("t1_raddr1", acc_raddr_o, 2);
        repeat (3) step();
        chk("t1_last_valid", stream_valid_o, 1);
        chk("t1_raddr_last", acc_raddr_o, 6);
        step();
        chk("t1_clear", acc_clear_o, 1);
        chk("t1_done", done_o, 1);
        chk("t1_valid_off", stream_valid_o, 0);
        step();
        chk("t1_busy_off", busy_o, 0);
        exp_done++;
        chk("t1_sb_empty", exp_q.size(), 0);

        // FULL, wc=13, ready 1,0,0,1: two beats, tail masked
        for (int i = 0; i < NW; i++) mem[i] = 32'h1000 + i;
        raddr_limit = 4;
        ready_mode  = 1;
        b0 = n_beats;
        push_full(0, 13);
        b.d = '0;
        for (int j = 0; j < 5; j++) b.d[j*32 +: 32] = 32'h1008 + j;
        b.s = 32'h000F_FFFF;
        exp_q.push_back(b);
        do_start(1'b0, 1'b0, 5'd0, 6'd13);
        wait_done(40);
        exp_done++;
        chk("t2_beats", n_beats - b0, 2);
        chk("t2_sb_empty", exp_q.size(), 0);
        ready_mode  = 0;
        raddr_limit = 8;
        step();

        // QUANT, wc=32, shift=4: single packed beat on cycle 4
        for (int i = 0; i < NW; i++) mem[i] = 32'h0;
        mem[0] = 32'h18; mem[1] = 32'hFFFF_FFE8; mem[2] = 32'h7FFF; mem[3] = 32'h8000_0000;
        mem[8] = 32'h10; mem[31] = 32'hFFFF_F808;
        b.d = '0;
        b.d[7:0] = 8'h02; b.d[15:8] = 8'hFF; b.d[23:16] = 8'h7F; b.d[31:24] = 8'h80;
        b.d[71:64] = 8'h01; b.d[255:248] = 8'h81;
        b.s = 32'hFFFF_FFFF;
        exp_q.push_back(b);
        do_start(1'b1, 1'b0, 5'd4, 6'd32);
        chk("t3_valid_c1", stream_valid_o, 0);
        step();
        chk("t3_valid_c2", stream_valid_o, 0);
        step();
        chk("t3_valid_c3", stream_valid_o, 0);
        step();
        chk("t3_valid_c4", stream_valid_o, 1);
        wait_done(10);
        exp_done++;
        chk("t3_sb_empty", exp_q.size(), 0);

        // QUANT, relu, shift=0, wc=3
        mem[0] = 32'hFFFF_FFFB; mem[1] = 32'd200; mem[2] = 32'd5; mem[3] = 32'd99;
        b.d = 256'h05_7F_00;
        b.s = 32'h0000_0007;
        exp_q.push_back(b);
        do_start(1'b1, 1'b1, 5'd0, 6'd3);
        chk("t4_valid", stream_valid_o, 1);
        wait_done(10);
        exp_done++;
        chk("t4_sb_empty", exp_q.size(), 0);

        // abort with clear_i while stalled, then re-drain from chunk 0
        fill_index();
        ready_mode = 2;
        do_start(1'b0, 1'b0, 5'd0, 6'd32);
        repeat (2) step();
        chk("t5_stalled_valid", stream_valid_o, 1);
        c0 = n_clear;
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        chk("t5_abort_valid", stream_valid_o, 0);
        chk("t5_abort_busy", busy_o, 0);
        chk("t5_abort_data", stream_data_o, 0);
        repeat (3) step();
        chk("t5_no_clear", n_clear, c0);
        chk("t5_no_done", n_done, exp_done);
        ready_mode = 0;
        for (int c = 0; c < 4; c++) push_full(c, 32);
        do_start(1'b0, 1'b0, 5'd0, 6'd32);
        chk("t5_restart_raddr", acc_raddr_o, 2);
        wait_done(20);
        exp_done++;
        chk("t5_sb_empty", exp_q.size(), 0);

        // guards: zero word count, start while busy, reset during PACK_OUT
        do_start(1'b0, 1'b0, 5'd0, 6'd0);
        chk("t6_wc0_busy", busy_o, 0);
        step();
        chk("t6_wc0_busy2", busy_o, 0);
        b0 = n_beats;
        push_full(0, 16);
        push_full(1, 16);
        do_start(1'b0, 1'b0, 5'd0, 6'd16);
        word_count_i = 6'd32;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        wait_done(20);
        exp_done++;
        chk("t6_busy_start_beats", n_beats - b0, 2);
        chk("t6_sb_empty", exp_q.size(), 0);

        ready_mode = 2;
        c0 = n_clear;
        do_start(1'b1, 1'b0, 5'd0, 6'd32);
        repeat (3) step();
        chk("t6_pack_valid", stream_valid_o, 1);
        rst_i = 1'b1;
        step();
        chk("t6_rst_valid", stream_valid_o, 0);
        chk("t6_rst_data", stream_data_o, 0);
        chk("t6_rst_strb", stream_strb_o, 0);
        chk("t6_rst_busy", busy_o, 0);
        chk("t6_rst_raddr", acc_raddr_o, 0);
        chk("t6_rst_clear", acc_clear_o, 0);
        chk("t6_rst_done", done_o, 0);
        rst_i = 1'b0;
        repeat (3) step();
        chk("t6_no_clear", n_clear, c0);
        chk("final_done_count", n_done, exp_done);
        chk("final_clear_count", n_clear, exp_done);
        chk("final_sb_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
